// File: rtl/andor3_sweep.sv
// andor3_sweep
// Exhaustive stimulus-and-capture stage for a 3-input AND-OR block.
// On an accepted start it drives each {c,b,a} combination 0..7 in turn.
// Each vector is held for HOLD_CYCLES settling cycles and then sampled once.
// The captured y/z responses are presented as two 8-bit truth-table words.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - sweep request, acted on only when idle
//   y, z      - outputs of the AND-OR stage under test
//   a, b, c   - stimulus bits (vec_idx bits while busy, else 0)
//   vec_idx   - index of the vector currently driven, 0 when idle
//   busy      - high while vectors are being driven/sampled
//   done      - one-cycle pulse after the last sample
//   result_y  - bit i = y captured for vector i
//   result_z  - bit i = z captured for vector i
module andor3_sweep #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  input  logic       z,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic [7:0] result_y,
  output logic [7:0] result_z
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Last counter value seen in DRIVE before moving to SAMPLE.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic [2:0] idx_nx;
  logic       busy_nx;
  logic       done_nx;
  logic [7:0] ry_nx;
  logic [7:0] rz_nx;

  // Next-state and next-output logic.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = vec_idx;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    ry_nx    = result_y;
    rz_nx    = result_z;
    case (state)
      // The closing edge of DONE behaves like an IDLE edge, so a start that
      // is held high restarts the sweep on the first edge after DONE.
      S_IDLE, S_DONE: begin
        idx_nx = 3'd0;
        if (start) begin
          state_nx = S_DRIVE;
          cnt_nx   = 8'd0;
          ry_nx    = 8'd0;
          rz_nx    = 8'd0;
          busy_nx  = 1'b1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_DRIVE: begin
        busy_nx = 1'b1;
        cnt_nx  = cnt + 8'd1;
        if (cnt == HOLD_LAST) begin
          state_nx = S_SAMPLE;
        end else begin
          state_nx = S_DRIVE;
        end
      end
      S_SAMPLE: begin
        ry_nx[vec_idx] = y;
        rz_nx[vec_idx] = z;
        if (vec_idx == 3'd7) begin
          state_nx = S_DONE;
          idx_nx   = 3'd0;
          done_nx  = 1'b1;
        end else begin
          state_nx = S_DRIVE;
          idx_nx   = vec_idx + 3'd1;
          cnt_nx   = 8'd0;
          busy_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        idx_nx   = 3'd0;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 8'd0;
      vec_idx  <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result_y <= 8'd0;
      result_z <= 8'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      vec_idx  <= idx_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      result_y <= ry_nx;
      result_z <= rz_nx;
    end
  end

  // Stimulus follows the registered index; gated so it is 0 whenever idle.
  assign a = busy & vec_idx[0];
  assign b = busy & vec_idx[1];
  assign c = busy & vec_idx[2];

endmodule

// File: doc/andor3_sweep.md
# andor3_sweep

Sequential stimulus-and-capture stage that sits directly upstream of the 3-input AND-OR stage. On a start request it walks all eight {c,b,a} input combinations and drives them onto the stage's a/b/c inputs. It holds each vector for a programmable settling time, then samples the stage's y/z outputs. The sixteen captured response bits are presented as two 8-bit truth-table words with a one-cycle done pulse, so the AND-OR logic can be exercised exhaustively in-system without a free-running toggle bench.

## Interface

- HOLD_CYCLES, 2, settling cycles each vector is driven before its sample cycle; legal range 1..255.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low; one clock, no other reset.
- start  in  1  sweep request; acted on only in IDLE.
- y  in  1  AND-OR stage output y.
- z  in  1  AND-OR stage output z.
- a  out  1  stimulus bit a = vec_idx[0] while busy, else 0.
- b  out  1  stimulus bit b = vec_idx[1] while busy, else 0.
- c  out  1  stimulus bit c = vec_idx[2] while busy, else 0.
- vec_idx  out  3  index of the vector currently driven; 0 when idle.
- busy  out  1  high in DRIVE and SAMPLE.
- done  out  1  one-cycle pulse after the last sample.
- result_y  out  8  bit i = y captured for vector i.
- result_z  out  8  bit i = z captured for vector i.

## Operation

- FSM states: IDLE, DRIVE, SAMPLE, DONE. Encoding is free.
- IDLE:
  - a/b/c = 0.
  - When start=1 at an edge: vec_idx<=0, hold counter<=0, result_y<=0, result_z<=0, go to DRIVE.
- DRIVE:
  - The counter increments each cycle.
  - After HOLD_CYCLES cycles in DRIVE, go to SAMPLE.
  - The counter is 8 bits wide.
- SAMPLE (one cycle):
  - At its closing edge: result_y[vec_idx]<=y and result_z[vec_idx]<=z.
  - If vec_idx==7, go to DONE.
  - Otherwise vec_idx<=vec_idx+1, counter<=0, return to DRIVE.
  - vec_idx never wraps inside a sweep.
- DONE (one cycle): done=1, busy=0, a/b/c=0, vec_idx=0, then IDLE.
- start is ignored in DRIVE, SAMPLE and DONE; no queuing.
- start held high continuously: a new sweep begins on the first edge after the block returns to IDLE.
- result_y/result_z hold their values from DONE until the next accepted start, which clears them.
- a/b/c are combinational from vec_idx and state, with no extra register stage. They change only on clock edges.

## Timing

- Reset values of all outputs are 0: a, b, c, vec_idx, busy, done, result_y, result_z. State is IDLE.
- Start accepted at edge k:
  - busy and vector 0 are visible from k.
  - Each vector occupies HOLD_CYCLES+1 cycles: HOLD_CYCLES of DRIVE plus one SAMPLE.
  - y/z are sampled HOLD_CYCLES+1 edges after the vector is applied.
- done is high in the cycle starting at edge k+8*(HOLD_CYCLES+1).
  - With HOLD_CYCLES=2, that is edge k+24.
  - The earliest next start is accepted at edge k+25.
- Reset asserted mid-sweep:
  - Outputs clear immediately, without waiting for a clock; a partially captured result is discarded.
  - After rst_n rises, the block stays in IDLE until start is seen.
- y/z must be stable for the sample edge. Any glitches during DRIVE have no effect.

## Test plan

- Reset then idle: rst_n=0 for 3 cycles, then 1, start=0 for 10 cycles -> all outputs 0 throughout, no done.
- Bench model y=(a&b)|c, z=~y, HOLD_CYCLES=2, one start pulse -> vec_idx steps 0..7 every 3 cycles; done pulses exactly 24 cycles after the start edge; result_y=8'hF8, result_z=8'h07.
- Loopback y=a, z=c -> result_y=8'hAA, result_z=8'hF0. A second start with y=b, z=0 -> results cleared at start, then result_y=8'hCC, result_z=8'h00.
- start pulsed again at vector 3 and again during DONE -> both ignored; single done pulse, results as for one sweep. start held high for 60 cycles with HOLD_CYCLES=2 -> done pulses at start edge +24 and +49.
- rst_n driven low asynchronously mid-cycle during vector 5 -> a/b/c, busy, vec_idx, result_y, result_z go to 0 before the next clock edge. No done follows until a fresh start.
- HOLD_CYCLES=1 and HOLD_CYCLES=255 -> done at 16 and 2048 cycles after the start edge respectively; results correct for the y=a, z=c loopback.
